// File: rtl/interp_pkg.sv
// interp_pkg: Q1.15 constants, default NCO steps and saturation/clamp helpers for the interpolation controller
package interp_pkg;
    localparam int          FRAC_BITS = 15;
    localparam logic [15:0] ONE       = 16'(1 << FRAC_BITS);
    localparam logic [15:0] UK_MAX    = ONE - 16'h1;
    localparam logic [15:0] W0_DEF    = 16'h4000;
    localparam logic [15:0] W_MIN_DEF = 16'h2000;
    localparam logic [15:0] W_MAX_DEF = 16'h6000;

    function automatic logic [15:0] sat_7fff(input logic [31:0] v);
        return (v > {16'h0, UK_MAX}) ? UK_MAX : v[15:0];
    endfunction

    function automatic logic [15:0] clamp_w(input logic signed [16:0] s, input logic [15:0] lo, input logic [15:0] hi);
        return (s < $signed({1'b0, lo})) ? lo : (s > $signed({1'b0, hi})) ? hi : s[15:0];
    endfunction
endpackage

// File: rtl/pulse_delay_line.sv
// pulse_delay_line: async-reset shift register delaying a WIDTH-bit word by DEPTH clocks (DEPTH=0 passes through)
module pulse_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DEPTH];
            // shift one stage per clock, unconditionally, so pulses keep draining while the NCO is paused
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end
            assign dout = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/interp_nco_ctrl.sv
// interp_nco_ctrl: modulo-1 decrementing NCO driving the Farrow interpolator with uk and an aligned strobe
module interp_nco_ctrl
    import interp_pkg::*;
#(
    parameter logic [15:0] W0         = W0_DEF,
    parameter logic [15:0] W_MIN      = W_MIN_DEF,
    parameter logic [15:0] W_MAX      = W_MAX_DEF,
    parameter int          OSR_LOG2   = 1,
    parameter int          STROBE_DLY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] w_adj,
    input  logic        w_adj_vld,
    output logic [15:0] uk,
    output logic        uk_vld,
    output logic        strobe,
    output logic        sym_sel,
    output logic [15:0] nco_eta
);
    logic [15:0]        eta;
    logic [15:0]        w_reg;
    logic               phase;
    logic [16:0]        diff;
    logic               uflow;
    logic signed [16:0] w_sum;
    logic [31:0]        eta_sh;

    assign diff    = {1'b0, eta} - {1'b0, w_reg};
    assign uflow   = diff[16];
    assign w_sum   = $signed({1'b0, W0}) + $signed({w_adj[15], w_adj});
    assign eta_sh  = {16'h0, eta} << OSR_LOG2;
    assign nco_eta = eta;

    // step register: the 17-bit sum is clamped, never wrapped, and applies from the next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_reg <= W0;
        else if (w_adj_vld) w_reg <= clamp_w(w_sum, W_MIN, W_MAX);
    end

    // NCO decrement with modulo-1 wrap; an underflow captures uk from the pre-update eta and flips the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eta    <= 16'h7FFF;
            uk     <= 16'h0;
            uk_vld <= 1'b0;
            phase  <= 1'b0;
        end else begin
            uk_vld <= en & uflow;
            if (en) begin
                eta <= uflow ? diff[15:0] + ONE : diff[15:0];
                if (uflow) begin
                    uk    <= sat_7fff(eta_sh);
                    phase <= ~phase;
                end
            end
        end
    end

    pulse_delay_line #(.WIDTH(2), .DEPTH(STROBE_DLY)) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({uk_vld, phase}),
        .dout ({strobe, sym_sel})
    );
endmodule
